// File: rtl/seq_compare_pkg.sv
// Shared types for the iterative magnitude comparator: FSM encodings and
// the index-counter width helper.
package seq_compare_pkg;

    // 2'd3 is unused; the FSM treats it as illegal and returns to idle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/seq_compare_if.sv
// Operand/result handshake bundle between a requester and seq_compare.
interface seq_compare_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_A;
    logic [WIDTH-1:0] data_B;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             lt;
    logic             eq;
    logic             gt;

    modport master (
        output in_valid, data_A, data_B, signed_mode, out_ready,
        input  in_ready, out_valid, lt, eq, gt
    );

    modport slave (
        input  in_valid, data_A, data_B, signed_mode, out_ready,
        output in_ready, out_valid, lt, eq, gt
    );
endinterface

// File: rtl/seq_compare_digit_compare.sv
// Combinational unsigned comparator for one digit, built as a ripple
// generate/propagate chain from LSB to MSB.
module digit_compare #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             eq
);
    logic [DIGIT-1:0] gen;
    logic [DIGIT-1:0] prop;
    logic [DIGIT:0]   chain;

    assign chain[0] = 1'b0;

    // A higher bit decides on its own; only when it matches does the lower verdict pass up.
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
        assign gen[gi]      = ~a[gi] & b[gi];
        assign prop[gi]     = ~(a[gi] ^ b[gi]);
        assign chain[gi+1]  = gen[gi] | (prop[gi] & chain[gi]);
    end

    assign lt = chain[DIGIT];
    assign eq = &prop;
endmodule

// File: rtl/seq_compare.sv
// Iterative MSB-first magnitude comparator: scans DIGIT bits per cycle and
// stops at the first differing digit; signed mode biases the sign bit.
module seq_compare
    import seq_compare_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    seq_compare_if.slave  bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = idx_width(NDIG);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("seq_compare: WIDTH must be a multiple of DIGIT");
    end

    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDXW-1:0]  IDX_TOP   = IDXW'(NDIG - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDXW-1:0]  idx_reg;
    logic             lt_reg;
    logic             eq_reg;
    logic             gt_reg;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic             dig_lt;
    logic             dig_eq;
    logic             last_digit;

    assign dig_a      = a_reg[int'(idx_reg) * DIGIT +: DIGIT];
    assign dig_b      = b_reg[int'(idx_reg) * DIGIT +: DIGIT];
    assign last_digit = (idx_reg == '0);

    digit_compare #(.DIGIT(DIGIT)) u_digit (
        .a  (dig_a),
        .b  (dig_b),
        .lt (dig_lt),
        .eq (dig_eq)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (bus.in_valid) state_next = S_SCAN;
            S_SCAN: if (!dig_eq || last_digit) state_next = S_DONE;
            S_DONE: if (bus.out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = reset && (state_reg == S_IDLE);
        bus.out_valid = (state_reg == S_DONE);
        bus.lt        = lt_reg;
        bus.eq        = eq_reg;
        bus.gt        = gt_reg;
    end

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            idx_reg <= '0;
            lt_reg  <= 1'b0;
            eq_reg  <= 1'b0;
            gt_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_reg   <= bus.data_A ^ (bus.signed_mode ? SIGN_MASK : '0);
                        b_reg   <= bus.data_B ^ (bus.signed_mode ? SIGN_MASK : '0);
                        idx_reg <= IDX_TOP;
                    end
                end
                S_SCAN: begin
                    if (!dig_eq) begin
                        lt_reg <= dig_lt;
                        gt_reg <= ~dig_lt;
                    end else if (last_digit) begin
                        eq_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg - 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        lt_reg <= 1'b0;
                        eq_reg <= 1'b0;
                        gt_reg <= 1'b0;
                    end
                end
                default: begin
                    lt_reg <= 1'b0;
                    eq_reg <= 1'b0;
                    gt_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_compare.sv
// Directed and randomised checks of seq_compare at WIDTH=32, DIGIT=4.
module tb_seq_compare;
    logic clock;
    logic reset;

    seq_compare_if #(.WIDTH(32)) bus ();

    seq_compare #(.WIDTH(32), .DIGIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        exp_lt;
        logic        exp_eq;
        logic        exp_gt;
        int          exp_k;
    } vec_t;

    vec_t vecs[10];
    int   checks;
    int   failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic start_txn(input logic [31:0] a, input logic [31:0] b, input logic s);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        check("in_ready_before_accept", bus.in_ready, 1);
        bus.data_A      = a;
        bus.data_B      = b;
        bus.signed_mode = s;
        bus.in_valid    = 1'b1;
        @(posedge clock); #1;
        bus.in_valid    = 1'b0;
        bus.data_A      = $urandom;
        bus.data_B      = $urandom;
        bus.signed_mode = 1'($urandom);
    endtask

    task automatic wait_result(output logic rlt, output logic req, output logic rgt, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        rlt = bus.lt;
        req = bus.eq;
        rgt = bus.gt;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        check("post_consume_out_valid", bus.out_valid, 0);
        check("post_consume_in_ready", bus.in_ready, 1);
    endtask

    task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic elt, input logic eeq,
                                 input logic egt, input int ek);
        logic rlt, req, rgt;
        int   lat;
        start_txn(a, b, s);
        wait_result(rlt, req, rgt, lat);
        check({tag, "_lt"}, rlt, elt);
        check({tag, "_eq"}, req, eeq);
        check({tag, "_gt"}, rgt, egt);
        check({tag, "_onehot"}, 32'(rlt) + 32'(req) + 32'(rgt), 1);
        check({tag, "_latency"}, lat, ek);
        $display("%s a=%08h b=%08h s=%0d lt=%0d eq=%0d gt=%0d lat=%0d", tag, a, b, s, rlt, req, rgt, lat);
        consume();
    endtask

    function automatic int model_k(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = a ^ b;
        for (int i = 7; i >= 0; i--) begin
            if (d[i*4 +: 4] != 4'h0) return 8 - i;
        end
        return 8;
    endfunction

    initial begin
        logic rlt, req, rgt;
        int   lat;
        logic [31:0] ra, rb;
        logic        rs;
        logic        mlt, meq, mgt;
        int          pick;

        checks   = 0;
        failures = 0;

        vecs[0] = '{32'h00000001, 32'h00000002, 1'b0, 1'b1, 1'b0, 1'b0, 8};
        vecs[1] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        vecs[2] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[3] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 8};
        vecs[4] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 8};
        vecs[5] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[6] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        vecs[7] = '{32'h12345678, 32'h12340678, 1'b0, 1'b0, 1'b0, 1'b1, 5};
        vecs[8] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 8};
        vecs[9] = '{32'h00000005, 32'hFFFFFFFD, 1'b1, 1'b0, 1'b0, 1'b1, 1};

        reset           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.data_A      = '0;
        bus.data_B      = '0;
        bus.signed_mode = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_flags", {29'd0, bus.lt, bus.eq, bus.gt}, 0);
        reset = 1'b1;
        #1;
        check("release_in_ready", bus.in_ready, 1);
        $display("reset released in_ready=%0d", bus.in_ready);

        for (int i = 0; i < 10; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                          vecs[i].exp_lt, vecs[i].exp_eq, vecs[i].exp_gt, vecs[i].exp_k);
        end

        // Result held in DONE while new operands are offered.
        start_txn(32'h00000001, 32'h00000002, 1'b0);
        wait_result(rlt, req, rgt, lat);
        check("hold_initial_lt", rlt, 1);
        bus.data_A      = 32'h00000055;
        bus.data_B      = 32'h00000044;
        bus.signed_mode = 1'b0;
        bus.in_valid    = 1'b1;
        repeat (5) begin
            @(posedge clock); #1;
            check("hold_lt", bus.lt, 1);
            check("hold_eq_gt", {30'd0, bus.eq, bus.gt}, 0);
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("hold_release_in_ready", bus.in_ready, 1);
        check("hold_release_out_valid", bus.out_valid, 0);
        check("hold_release_flags", {29'd0, bus.lt, bus.eq, bus.gt}, 0);
        @(posedge clock); #1;
        check("hold_no_accept", bus.in_ready, 1);
        $display("hold sequence done in_ready=%0d", bus.in_ready);

        // Reset asserted mid-scan.
        start_txn(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("midscan_in_ready_low", bus.in_ready, 0);
        @(posedge clock); #1;
        check("midscan_out_valid", bus.out_valid, 0);
        check("midscan_flags", {29'd0, bus.lt, bus.eq, bus.gt}, 0);
        check("midscan_in_ready", bus.in_ready, 0);
        reset = 1'b1;
        #1;
        check("midscan_release_in_ready", bus.in_ready, 1);
        $display("midscan reset done");
        run_and_check("after_reset", 32'h12345678, 32'h12340678, 1'b0, 1'b0, 1'b0, 1'b1, 5);

        // Back-to-back random pairs against an arithmetic model.
        for (int n = 0; n < 1000; n++) begin
            ra   = $urandom;
            pick = $urandom_range(0, 3);
            case (pick)
                0: rb = $urandom;
                1: rb = ra;
                default: begin
                    rb = ra;
                    rb[$urandom_range(0, 31)] ^= 1'b1;
                end
            endcase
            rs = 1'($urandom);
            if (rs) begin
                mlt = $signed(ra) < $signed(rb);
                mgt = $signed(ra) > $signed(rb);
            end else begin
                mlt = ra < rb;
                mgt = ra > rb;
            end
            meq = (ra == rb);
            run_and_check($sformatf("rnd%0d", n), ra, rb, rs, mlt, meq, mgt, model_k(ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
